// File: rtl/rtc_bus_arbiter_if.sv
// Requester-side handshake bundle for the RTC bus arbiter.
// Masters raise requests; the arbiter returns acks, read data and busy.
interface rtc_bus_arbiter_if;
  logic       req0_valid;
  logic       req0_wr;
  logic [7:0] req0_addr;
  logic [7:0] req0_wdata;
  logic       req0_ack;
  logic       req1_valid;
  logic       req1_wr;
  logic [7:0] req1_addr;
  logic [7:0] req1_wdata;
  logic       req1_ack;
  logic [7:0] rdata;
  logic       rdata_valid;
  logic       busy;

  modport master (
    output req0_valid, req0_wr, req0_addr, req0_wdata,
    output req1_valid, req1_wr, req1_addr, req1_wdata,
    input  req0_ack, req1_ack, rdata, rdata_valid, busy
  );

  modport slave (
    input  req0_valid, req0_wr, req0_addr, req0_wdata,
    input  req1_valid, req1_wr, req1_addr, req1_wdata,
    output req0_ack, req1_ack, rdata, rdata_valid, busy
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// RTC mux-bus arbiter: two requesters, one latched transaction per grant.
// Define RTC_ARB_FIXED_PRIO_EN for fixed req1 priority (default: round robin).
module rtc_bus_arbiter #(
  parameter int T_PHASE = 10,
  parameter int T_GAP   = 4
) (
  input  logic             clk,
  input  logic             reset,
  rtc_bus_arbiter_if.slave rq,
  output logic             cs_n,
  output logic             ad_n,
  output logic             rd_n,
  output logic             wr_n,
  output logic [7:0]       bus_dout,
  output logic             bus_oe,
  input  logic [7:0]       bus_din
);

  localparam int TMAX = (T_PHASE > T_GAP) ? T_PHASE : T_GAP;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] PH_LD  = CW'(T_PHASE - 1);
  localparam logic [CW-1:0] GAP_LD = CW'(T_GAP - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_AREL = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DREL = 3'd4;
  localparam logic [2:0] S_GAP  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          id_q, id_d;
  logic          wr_q, wr_d;
  logic [7:0]    addr_q, addr_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          gnt1;
  logic          any_req;
  logic          last;
  logic          ack0, ack1, rvalid;

  assign any_req = rq.req0_valid | rq.req1_valid;
  assign last    = (cnt_q == '0);

`ifdef RTC_ARB_FIXED_PRIO_EN
  // PicoBlaze requester always wins a tie
  always_comb gnt1 = rq.req1_valid;
`else
  logic rr_q, rr_d;

  // tie goes to whichever requester was not granted last
  always_comb begin
    gnt1 = rq.req1_valid & (~rq.req0_valid | ~rr_q);
    rr_d = (state_q == S_IDLE && any_req) ? gnt1 : rr_q;
  end

  // last-granted pointer; reset value favours req1
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rr_q <= 1'b0;
    else       rr_q <= rr_d;
  end
`endif

  // phase sequencing, grant latch and read capture
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q != S_IDLE && !last) cnt_d = cnt_q - CW'(1);
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_ADDR;
          cnt_d   = PH_LD;
          id_d    = gnt1;
          wr_d    = gnt1 ? rq.req1_wr : rq.req0_wr;
          addr_d  = gnt1 ? rq.req1_addr : rq.req0_addr;
          wdata_d = gnt1 ? rq.req1_wdata : rq.req0_wdata;
        end
      end
      S_ADDR: begin
        if (last) begin
          state_d = S_AREL;
          cnt_d   = PH_LD;
        end
      end
      S_AREL: begin
        if (last) begin
          state_d = S_DATA;
          cnt_d   = PH_LD;
        end
      end
      S_DATA: begin
        if (last) begin
          state_d = S_DREL;
          cnt_d   = PH_LD;
          if (!wr_q) rdata_d = bus_din;
        end
      end
      S_DREL: begin
        if (last) begin
          state_d = S_GAP;
          cnt_d   = GAP_LD;
        end
      end
      S_GAP: begin
        if (last) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state registers; reset drops the transaction without an ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // strobe and tristate decode; io_port never driven while rd_n is low
  always_comb begin
    cs_n     = 1'b1;
    ad_n     = 1'b1;
    rd_n     = 1'b1;
    wr_n     = 1'b1;
    bus_oe   = 1'b0;
    bus_dout = '0;
    ack0     = 1'b0;
    ack1     = 1'b0;
    rvalid   = 1'b0;
    case (state_q)
      S_ADDR: begin
        cs_n     = 1'b0;
        ad_n     = 1'b0;
        wr_n     = 1'b0;
        bus_oe   = 1'b1;
        bus_dout = addr_q;
      end
      S_AREL: begin
        bus_oe   = 1'b1;
        bus_dout = addr_q;
      end
      S_DATA: begin
        cs_n = 1'b0;
        if (wr_q) begin
          wr_n     = 1'b0;
          bus_oe   = 1'b1;
          bus_dout = wdata_q;
        end else begin
          rd_n = 1'b0;
        end
      end
      S_DREL: begin
        if (wr_q) begin
          bus_oe   = 1'b1;
          bus_dout = wdata_q;
        end
        if (last) begin
          ack0   = ~id_q;
          ack1   = id_q;
          rvalid = ~wr_q;
        end
      end
      default: ;
    endcase
  end

  assign rq.req0_ack    = ack0;
  assign rq.req1_ack    = ack1;
  assign rq.rdata_valid = rvalid;
  assign rq.rdata       = rdata_q;
  assign rq.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter at T_PHASE=2, T_GAP=1.
// Cycle model: time since grant, divided into bus phases.
module tb_rtc_bus_arbiter;
  localparam int TP = 2;
  localparam int TG = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] bus_din = 8'h00;
  logic       cs_n, ad_n, rd_n, wr_n, bus_oe;
  logic [7:0] bus_dout;

  rtc_bus_arbiter_if bif ();

  rtc_bus_arbiter #(
    .T_PHASE(TP),
    .T_GAP  (TG)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rq      (bif),
    .cs_n    (cs_n),
    .ad_n    (ad_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .bus_dout(bus_dout),
    .bus_oe  (bus_oe),
    .bus_din (bus_din)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // model: m_t = cycles since grant edge, -1 when idle
  int         m_t = -1;
  logic       m_id = 1'b0;
  logic       m_wr = 1'b0;
  logic       m_last = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic [7:0] m_wdata = 8'h00;
  logic [7:0] m_rdata = 8'h00;
  logic       ack_evt = 1'b0;
  logic       ack_id = 1'b0;

  task automatic model_reset();
    m_t = -1;
    m_last = 1'b0;
    m_rdata = 8'h00;
    ack_evt = 1'b0;
  endtask

  task automatic model_edge();
    logic v0, v1, g1;
    if (reset) begin
      model_reset();
      return;
    end
    v0 = bif.req0_valid;
    v1 = bif.req1_valid;
    if (m_t < 0) begin
      if (v0 || v1) begin
`ifdef RTC_ARB_FIXED_PRIO_EN
        g1 = v1;
`else
        g1 = v1 && (!v0 || !m_last);
`endif
        m_last  = g1;
        m_id    = g1;
        m_wr    = g1 ? bif.req1_wr : bif.req0_wr;
        m_addr  = g1 ? bif.req1_addr : bif.req0_addr;
        m_wdata = g1 ? bif.req1_wdata : bif.req0_wdata;
        m_t     = 0;
      end
    end else begin
      if (m_t == 3*TP-1 && !m_wr) m_rdata = bus_din;
      if (m_t == 4*TP-1) begin
        ack_evt = 1'b1;
        ack_id  = m_id;
      end
      m_t++;
      if (m_t == 4*TP+TG) m_t = -1;
    end
  endtask

  function automatic logic [24:0] exp_vec();
    logic cs, ad, rd, wr, oe, bsy, a0, a1, rv;
    logic [7:0] d;
    cs = 1; ad = 1; rd = 1; wr = 1; oe = 0;
    bsy = 0; a0 = 0; a1 = 0; rv = 0; d = 8'h00;
    if (m_t >= 0) begin
      bsy = 1;
      case (m_t / TP)
        0: begin cs = 0; ad = 0; wr = 0; oe = 1; d = m_addr; end
        1: begin oe = 1; d = m_addr; end
        2: begin
          cs = 0;
          if (m_wr) begin wr = 0; oe = 1; d = m_wdata; end
          else rd = 0;
        end
        3: begin
          oe = m_wr;
          d = m_wr ? m_wdata : 8'h00;
          if (m_t == 4*TP-1) begin
            a0 = !m_id; a1 = m_id; rv = !m_wr;
          end
        end
        default: ;
      endcase
    end
    return {cs, ad, rd, wr, oe, d, bsy, a0, a1, rv, m_rdata};
  endfunction

  function automatic logic [24:0] obs_vec();
    return {cs_n, ad_n, rd_n, wr_n, bus_oe,
            (bus_oe ? bus_dout : 8'h00), bif.busy,
            bif.req0_ack, bif.req1_ack, bif.rdata_valid, bif.rdata};
  endfunction

  task automatic advance();
    @(posedge clk);
    model_edge();
    #1;
    if (ack_evt) begin
      if (ack_id) bif.req1_valid = 1'b0;
      else        bif.req0_valid = 1'b0;
      ack_evt = 1'b0;
    end
  endtask

  task automatic settle();
    for (int i = 0; i < 30 && m_t >= 0; i++) advance();
  endtask

  task automatic issue(input logic id, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (id) begin
      bif.req1_wr = wr; bif.req1_addr = a;
      bif.req1_wdata = d; bif.req1_valid = 1'b1;
    end else begin
      bif.req0_wr = wr; bif.req0_addr = a;
      bif.req0_wdata = d; bif.req0_valid = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    issue(0, 0, 8'h10, 8'h00);
    for (int k = 0; k < 3; k++) begin
      advance();
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      n_cmp++;
      if (bus_dout !== 8'h00) begin
        n_bad++;
        $display("FAIL reset_dout got=%h exp=00", bus_dout);
      end
    end
    advance();
    reset = 1'b0;
    for (int k = 0; k < 14; k++) begin
      bus_din = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL reset_rel k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_write();
    int k_addr, k_ack;
    k_addr = -100;
    k_ack = 100;
    settle();
    issue(1, 1, 8'h21, 8'h45);
    for (int k = 0; k < 12; k++) begin
      advance();
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL write k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (!ad_n && k_addr < 0) k_addr = k;
      if (bif.req1_ack) k_ack = k;
    end
    n_cmp++;
    if (k_ack - k_addr !== 4*TP-1) begin
      n_bad++;
      $display("FAIL write_lat got=%0d exp=%0d", k_ack - k_addr, 4*TP-1);
    end
  endtask

  task automatic test_read();
    int n_rv;
    n_rv = 0;
    settle();
    issue(0, 0, 8'h22, 8'h00);
    for (int k = 0; k < 12; k++) begin
      advance();
      bus_din = (m_t >= 0 && m_t / TP == 2) ? 8'h59 : 8'hA5;
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL read k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      n_cmp++;
      if (bus_oe && !rd_n) begin
        n_bad++;
        $display("FAIL read_oe k=%0d got oe=1 rd_n=0 exp no overlap", k);
      end
      if (bif.rdata_valid) begin
        n_rv++;
        n_cmp++;
        if ({bif.req0_ack, bif.rdata} !== {1'b1, 8'h59}) begin
          n_bad++;
          $display("FAIL read_data got=%b/%h exp=1/59", bif.req0_ack, bif.rdata);
        end
      end
    end
    n_cmp++;
    if (n_rv !== 1) begin
      n_bad++;
      $display("FAIL read_rv_count got=%0d exp=1", n_rv);
    end
  endtask

  task automatic test_round_robin();
    int   ak[$];
    logic aw[$];
    logic want;
    reset = 1'b1;
    issue(0, 0, 8'h30, 8'h00);
    issue(1, 1, 8'h31, 8'h77);
    advance();
    advance();
    reset = 1'b0;
    for (int k = 0; k < 45; k++) begin
      advance();
      bif.req0_valid = 1'b1;
      bif.req1_valid = 1'b1;
      bus_din = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rr k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (bif.req0_ack || bif.req1_ack) begin
        ak.push_back(k);
        aw.push_back(bif.req1_ack);
      end
    end
    bif.req0_valid = 1'b0;
    bif.req1_valid = 1'b0;
    n_cmp++;
    if (ak.size() < 4) begin
      n_bad++;
      $display("FAIL rr_count got=%0d exp>=4", ak.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef RTC_ARB_FIXED_PRIO_EN
        want = 1'b1;
`else
        want = (i % 2 == 0);
`endif
        n_cmp++;
        if (aw[i] !== want) begin
          n_bad++;
          $display("FAIL rr_order i=%0d got=req%0d exp=req%0d", i, aw[i], want);
        end
        if (i > 0) begin
          n_cmp++;
          if (ak[i] - ak[i-1] !== 4*TP+TG+1) begin
            n_bad++;
            $display("FAIL rr_period i=%0d got=%0d exp=%0d", i,
                     ak[i] - ak[i-1], 4*TP+TG+1);
          end
        end
      end
    end
  endtask

  task automatic test_drop();
    int n_ack;
    n_ack = 0;
    settle();
    issue(0, 0, 8'h33, 8'h00);
    for (int k = 0; k < 14; k++) begin
      advance();
      if (m_t >= TP && m_t < 2*TP) bif.req0_valid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL drop k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      if (bif.req0_ack) n_ack++;
    end
    n_cmp++;
    if (n_ack !== 1) begin
      n_bad++;
      $display("FAIL drop_ack got=%0d exp=1", n_ack);
    end
  endtask

  task automatic test_reset_mid();
    settle();
    issue(1, 1, 8'h5A, 8'hC3);
    for (int k = 0; k < 10 && m_t != 2*TP; k++) begin
      advance();
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rmid_pre k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    #1;
    reset = 1'b1;
    bif.req1_valid = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if ({cs_n, ad_n, rd_n, wr_n, bus_oe, bif.busy} !== 6'b111100) begin
      n_bad++;
      $display("FAIL rmid_async got=%b exp=111100",
               {cs_n, ad_n, rd_n, wr_n, bus_oe, bif.busy});
    end
    for (int k = 0; k < 3; k++) begin
      advance();
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rmid_hold k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
    advance();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rmid_idle k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
      advance();
    end
    issue(0, 1, 8'h66, 8'h99);
    for (int k = 0; k < 12; k++) begin
      advance();
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL rmid_next k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic busy0, busy1;
    for (int k = 0; k < 400; k++) begin
      advance();
      busy0 = (m_t >= 0 && m_t < 4*TP && m_id == 1'b0);
      busy1 = (m_t >= 0 && m_t < 4*TP && m_id == 1'b1);
      if (!bif.req0_valid && !busy0 && $urandom_range(0, 3) == 0)
        issue(0, 1'($urandom), 8'($urandom), 8'($urandom));
      if (!bif.req1_valid && !busy1 && $urandom_range(0, 3) == 0)
        issue(1, 1'($urandom), 8'($urandom), 8'($urandom));
      if (busy0 && $urandom_range(0, 3) == 0) begin
        bif.req0_addr = 8'($urandom);
        bif.req0_wdata = 8'($urandom);
        bif.req0_wr = 1'($urandom);
      end
      if (busy1 && $urandom_range(0, 3) == 0) begin
        bif.req1_addr = 8'($urandom);
        bif.req1_wdata = 8'($urandom);
        bif.req1_wr = 1'($urandom);
      end
      if (busy0 && $urandom_range(0, 15) == 0) bif.req0_valid = 1'b0;
      if (busy1 && $urandom_range(0, 15) == 0) bif.req1_valid = 1'b0;
      bus_din = 8'($urandom);
      @(negedge clk);
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++;
        $display("FAIL random k=%0d got=%h exp=%h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    bif.req0_valid = 1'b0; bif.req0_wr = 1'b0;
    bif.req0_addr = 8'h00; bif.req0_wdata = 8'h00;
    bif.req1_valid = 1'b0; bif.req1_wr = 1'b0;
    bif.req1_addr = 8'h00; bif.req1_wdata = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_drop();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
